// File: rtl/multi_pattern_generator_pkg.sv
// rtl/multi_pattern_generator_pkg.sv - pattern codes and colour-bar table shared by the generator
package multi_pattern_generator_pkg;

    localparam logic [3:0] PAT_BLACK    = 4'd0;
    localparam logic [3:0] PAT_RED      = 4'd1;
    localparam logic [3:0] PAT_GREEN    = 4'd2;
    localparam logic [3:0] PAT_BLUE     = 4'd3;
    localparam logic [3:0] PAT_WHITE    = 4'd4;
    localparam logic [3:0] PAT_BARS     = 4'd5;
    localparam logic [3:0] PAT_CHECKER  = 4'd6;
    localparam logic [3:0] PAT_GRADIENT = 4'd7;
    localparam logic [3:0] PAT_BORDER   = 4'd8;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_flags_t;

    // Entry 0 (rightmost) is the leftmost bar on screen.
    localparam rgb_flags_t [7:0] BAR_TABLE = {
        rgb_flags_t'(3'b000),   // 7 black
        rgb_flags_t'(3'b001),   // 6 blue
        rgb_flags_t'(3'b100),   // 5 red
        rgb_flags_t'(3'b101),   // 4 magenta
        rgb_flags_t'(3'b010),   // 3 green
        rgb_flags_t'(3'b011),   // 2 cyan
        rgb_flags_t'(3'b110),   // 1 yellow
        rgb_flags_t'(3'b111)    // 0 white
    };

endpackage

// File: rtl/multi_pattern_generator_pixel_position_counter.sv
// rtl/multi_pattern_generator_pixel_position_counter.sv - sync delay, column/row counters and frame-start detect
module pixel_position_counter #(
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int COL_W       = $clog2(ACTIVE_COLS),
    parameter int ROW_W       = $clog2(ACTIVE_ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hsync,
    input  logic             vsync,
    output logic             hs_d1,
    output logic             vs_d1,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             frame_start
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(ACTIVE_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ACTIVE_ROWS - 1);

    logic active;
    logic vs_armed;

    assign active = hsync & vsync;

    // A frame start needs VSync seen low since reset, so releasing reset
    // in the middle of a frame does not count as a new frame.
    assign frame_start = vsync & ~vs_d1 & vs_armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_d1    <= 1'b0;
            vs_d1    <= 1'b0;
            col      <= '0;
            row      <= '0;
            vs_armed <= 1'b0;
        end else begin
            hs_d1 <= hsync;
            vs_d1 <= vsync;

            if (active && hs_d1 && vs_d1) begin
                if (col != COL_MAX) begin
                    col <= col + 1'b1;
                end
            end else begin
                col <= '0;
            end

            if (!vsync) begin
                row <= '0;
            end else if (hs_d1 && !hsync && (row != ROW_MAX)) begin
                row <= row + 1'b1;
            end

            if (!vsync) begin
                vs_armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_pattern_generator.sv
// rtl/multi_pattern_generator.sv - two-stage video test pattern generator
module multi_pattern_generator
    import multi_pattern_generator_pkg::*;
#(
    parameter int VIDEO_WIDTH = 3,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int CB_SHIFT    = 5
) (
    input  logic                   CLK,
    input  logic                   i_Reset,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    input  logic [3:0]             i_Pattern,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [VIDEO_WIDTH-1:0] o_Red,
    output logic [VIDEO_WIDTH-1:0] o_Green,
    output logic [VIDEO_WIDTH-1:0] o_Blue
);

    localparam int COL_W = $clog2(ACTIVE_COLS);
    localparam int ROW_W = $clog2(ACTIVE_ROWS);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(ACTIVE_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ACTIVE_ROWS - 1);
    localparam logic [VIDEO_WIDTH-1:0] CH_MAX = {VIDEO_WIDTH{1'b1}};

    logic             hs_d1;
    logic             vs_d1;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             frame_start;
    logic [3:0]       mode;

    logic [31:0]            col_ext;
    logic [2:0]             bar_idx;
    rgb_flags_t             bar_rgb;
    logic [VIDEO_WIDTH-1:0] grad;
    logic [VIDEO_WIDTH-1:0] red_n;
    logic [VIDEO_WIDTH-1:0] green_n;
    logic [VIDEO_WIDTH-1:0] blue_n;

    pixel_position_counter #(
        .ACTIVE_COLS (ACTIVE_COLS),
        .ACTIVE_ROWS (ACTIVE_ROWS),
        .COL_W       (COL_W),
        .ROW_W       (ROW_W)
    ) u_pos (
        .clk         (CLK),
        .reset       (i_Reset),
        .hsync       (i_HSync),
        .vsync       (i_VSync),
        .hs_d1       (hs_d1),
        .vs_d1       (vs_d1),
        .col         (col),
        .row         (row),
        .frame_start (frame_start)
    );

    // Loaded on the same edge as the first pixel's position, so a pixel
    // coincident with the VSync rising edge already sees the new pattern.
    always_ff @(posedge CLK) begin
        if (i_Reset) begin
            mode <= PAT_BLACK;
        end else if (frame_start) begin
            mode <= i_Pattern;
        end
    end

    assign col_ext = 32'(col);
    assign bar_idx = 3'((col_ext * 32'd8) / 32'(ACTIVE_COLS));
    assign grad    = VIDEO_WIDTH'((col_ext << VIDEO_WIDTH) / 32'(ACTIVE_COLS));
    assign bar_rgb = BAR_TABLE[bar_idx];

    always_comb begin
        red_n   = '0;
        green_n = '0;
        blue_n  = '0;
        if (hs_d1 && vs_d1) begin
            case (mode)
                PAT_RED:   red_n   = CH_MAX;
                PAT_GREEN: green_n = CH_MAX;
                PAT_BLUE:  blue_n  = CH_MAX;
                PAT_WHITE: begin
                    red_n   = CH_MAX;
                    green_n = CH_MAX;
                    blue_n  = CH_MAX;
                end
                PAT_BARS: begin
                    red_n   = bar_rgb.r ? CH_MAX : '0;
                    green_n = bar_rgb.g ? CH_MAX : '0;
                    blue_n  = bar_rgb.b ? CH_MAX : '0;
                end
                PAT_CHECKER: begin
                    if (col[CB_SHIFT] ^ row[CB_SHIFT]) begin
                        red_n   = CH_MAX;
                        green_n = CH_MAX;
                        blue_n  = CH_MAX;
                    end
                end
                PAT_GRADIENT: begin
                    red_n   = grad;
                    green_n = grad;
                    blue_n  = grad;
                end
                PAT_BORDER: begin
                    if ((col == '0) || (col == COL_MAX) || (row == '0) || (row == ROW_MAX)) begin
                        red_n   = CH_MAX;
                        green_n = CH_MAX;
                        blue_n  = CH_MAX;
                    end
                end
                default: begin
                    red_n   = '0;
                    green_n = '0;
                    blue_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (i_Reset) begin
            o_HSync <= 1'b0;
            o_VSync <= 1'b0;
            o_Red   <= '0;
            o_Green <= '0;
            o_Blue  <= '0;
        end else begin
            o_HSync <= hs_d1;
            o_VSync <= vs_d1;
            o_Red   <= red_n;
            o_Green <= green_n;
            o_Blue  <= blue_n;
        end
    end

endmodule

// File: tb/tb_multi_pattern_generator.sv
// tb/tb_multi_pattern_generator.sv - directed table and sequence checks for multi_pattern_generator
module tb_multi_pattern_generator;

    logic       CLK = 1'b0;
    logic       rst;
    logic       hs;
    logic       vs;
    logic [3:0] pat;
    logic       o_HSync;
    logic       o_VSync;
    logic [2:0] o_Red;
    logic [2:0] o_Green;
    logic [2:0] o_Blue;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_row;

    localparam logic [8:0] BAR_EXP [8] = '{9'o777, 9'o770, 9'o077, 9'o070,
                                           9'o707, 9'o700, 9'o007, 9'o000};

    typedef struct {
        logic        rst;
        logic        hs;
        logic        vs;
        logic [3:0]  pat;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t vq[$];

    multi_pattern_generator dut (
        .CLK       (CLK),
        .i_Reset   (rst),
        .i_HSync   (hs),
        .i_VSync   (vs),
        .i_Pattern (pat),
        .o_HSync   (o_HSync),
        .o_VSync   (o_VSync),
        .o_Red     (o_Red),
        .o_Green   (o_Green),
        .o_Blue    (o_Blue)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] got;
        got = {o_HSync, o_VSync, o_Red, o_Green, o_Blue};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got hs/vs/rgb=%b/%b/%o required %b/%b/%o",
                     name, got[10], got[9], got[8:0], exp[10], exp[9], exp[8:0]);
        end
    endtask

    task automatic add(input logic r, input logic h, input logic v, input logic [3:0] p,
                       input logic [10:0] e, input string n);
        vec_t t;
        t.rst = r; t.hs = h; t.vs = v; t.pat = p; t.exp = e; t.name = n;
        vq.push_back(t);
    endtask

    function automatic logic [8:0] exp_rgb(input int kind, input int c, input int r);
        int g;
        case (kind)
            1: return 9'o700;
            2: return 9'o070;
            3: return 9'o007;
            4: return 9'o777;
            5: return BAR_EXP[c / 80];
            6: return (((c / 32) % 2) != ((r / 32) % 2)) ? 9'o777 : 9'o000;
            7: begin
                g = c / 80;
                return {g[2:0], g[2:0], g[2:0]};
            end
            8: return (c == 0 || c == 639 || r == 0 || r == 479) ? 9'o777 : 9'o000;
            default: return 9'o000;
        endcase
    endfunction

    task automatic new_frame(input logic [3:0] p);
        hs = 1'b0; vs = 1'b0; pat = p;
        tick();
        tick();
        vs = 1'b1;
        tick();
        cur_row = 0;
    endtask

    // Streams one line of n active pixels followed by one blank cycle.
    task automatic run_line(input int n, input int kind, input bit chk);
        int c;
        for (int i = 0; i <= n; i++) begin
            hs = (i < n);
            vs = 1'b1;
            tick();
            if (chk && i >= 1) begin
                c = (i - 1 > 639) ? 639 : i - 1;
                check($sformatf("line_k%0d_r%0d_p%0d", kind, cur_row, i - 1),
                      {2'b11, exp_rgb(kind, c, cur_row)});
            end
        end
        if (cur_row < 479) cur_row++;
    endtask

    initial begin
        rst = 1'b1; hs = 1'b0; vs = 1'b0; pat = 4'd0;

        // Each row's expectation is the result of the previous row's inputs.
        add(1, 0, 0, 4'd0, {2'b00, 9'o000}, "reset_a");
        add(1, 0, 0, 4'd0, {2'b00, 9'o000}, "reset_b");
        add(0, 0, 0, 4'd1, {2'b00, 9'o000}, "release");
        add(0, 1, 1, 4'd1, {2'b00, 9'o000}, "pulse_n1");
        add(0, 0, 0, 4'd1, {2'b11, 9'o700}, "pulse_red");
        add(0, 0, 0, 4'd1, {2'b00, 9'o000}, "pulse_after");
        add(0, 0, 1, 4'd4, {2'b00, 9'o000}, "vs_rise_w");
        add(0, 1, 1, 4'd4, {2'b01, 9'o000}, "vs_only");
        add(0, 1, 1, 4'd2, {2'b11, 9'o777}, "white_a");
        add(0, 0, 1, 4'd2, {2'b11, 9'o777}, "white_hold");
        add(0, 0, 0, 4'd2, {2'b01, 9'o000}, "blank_vs");
        add(0, 0, 1, 4'd2, {2'b00, 9'o000}, "idle");
        add(0, 1, 1, 4'd3, {2'b01, 9'o000}, "vs_only_g");
        add(0, 0, 0, 4'd3, {2'b11, 9'o070}, "green");
        add(0, 1, 1, 4'd9, {2'b00, 9'o000}, "idle_b");
        add(0, 0, 0, 4'd9, {2'b11, 9'o000}, "mode9_black");
        add(0, 1, 1, 4'd3, {2'b00, 9'o000}, "idle_c");
        add(0, 0, 0, 4'd3, {2'b11, 9'o007}, "blue");

        foreach (vq[k]) begin
            rst = vq[k].rst; hs = vq[k].hs; vs = vq[k].vs; pat = vq[k].pat;
            tick();
            check(vq[k].name, vq[k].exp);
        end

        // Reset mid-line while white is showing.
        new_frame(4'd4);
        hs = 1'b1;
        tick();
        tick();
        check("pre_rst_white", {2'b11, 9'o777});
        rst = 1'b1;
        tick();
        check("mid_rst_zero", {2'b00, 9'o000});
        rst = 1'b0;
        tick();
        check("post_rst_first", {2'b00, 9'o000});
        tick();
        check("post_rst_black_a", {2'b11, 9'o000});
        tick();
        check("post_rst_black_b", {2'b11, 9'o000});
        hs = 1'b0;
        tick();
        run_line(3, 0, 1);
        new_frame(4'd4);
        run_line(2, 4, 1);

        // Colour bars over a full line.
        new_frame(4'd5);
        run_line(640, 5, 1);

        // Checkerboard corners.
        new_frame(4'd6);
        run_line(64, 6, 1);
        for (int r = 1; r < 32; r++) run_line(1, 6, 0);
        run_line(40, 6, 1);

        // Gradient.
        new_frame(4'd7);
        run_line(100, 7, 1);

        // Pattern change mid-frame is deferred to the next frame.
        new_frame(4'd2);
        run_line(4, 2, 1);
        pat = 4'd3;
        run_line(4, 2, 1);
        new_frame(4'd3);
        run_line(2, 3, 1);

        // Border with column and row saturation.
        new_frame(4'd8);
        run_line(8, 8, 1);
        run_line(700, 8, 1);
        while (cur_row < 240) run_line(1, 8, 0);
        run_line(640, 8, 1);
        while (cur_row < 479) run_line(1, 8, 0);
        run_line(10, 8, 1);
        run_line(5, 8, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_pattern_generator.md
MULTI_PATTERN_GENERATOR -- requirements
Module: multi_pattern_generator

Interface
REQ-001 Parameter VIDEO_WIDTH, default 3, bits per colour channel.
REQ-002 Parameter ACTIVE_COLS, default 640, active pixels per line.
REQ-003 Parameter ACTIVE_ROWS, default 480, active lines per frame.
REQ-004 Parameter CB_SHIFT, default 5, checkerboard square size of 2^CB_SHIFT pixels.
REQ-005 Port CLK, input, 1 bit, the only clock; all logic is on its rising edge.
REQ-006 Port i_Reset, input, 1 bit, synchronous, active-high reset.
REQ-007 Port i_HSync, input, 1 bit, high while the line is in the active horizontal region.
REQ-008 Port i_VSync, input, 1 bit, high while the frame is in the active vertical region.
REQ-009 Port i_Pattern, input, 4 bits, pattern select; sampled once per frame.
REQ-010 Port o_HSync, output, 1 bit, i_HSync delayed to align with colour.
REQ-011 Port o_VSync, output, 1 bit, i_VSync delayed to align with colour.
REQ-012 Ports o_Red, o_Green and o_Blue, outputs, each VIDEO_WIDTH bits, pixel colour; MAX means all ones.

Function
REQ-013 Pixel active when i_HSync=1 and i_VSync=1. Outputs for input cycle n appear at cycle n+2, all outputs registered.
REQ-014 Stage 1 registers: hs_d1, vs_d1, col, row, mode.
 - col = 0 on the first active cycle of a line, +1 on each following active cycle, saturating at ACTIVE_COLS-1.
 - col = 0 whenever the pixel is inactive.
REQ-015 row +1 on each falling edge of i_HSync (hs_d1=1, i_HSync=0) while i_VSync=1, saturating at ACTIVE_ROWS-1. row = 0 whenever i_VSync=0.
REQ-016 mode loads i_Pattern only on a rising edge of i_VSync (i_VSync=1, vs_d1=0). Changes to i_Pattern mid-frame have no effect until the next frame.
REQ-017 Stage 2 registers o_HSync<=hs_d1 and o_VSync<=vs_d1. Colour is all-zero when hs_d1&vs_d1=0; otherwise colour is selected by mode:
 - 0: black.
 - 1: red only at MAX.
 - 2: green only at MAX.
 - 3: blue only at MAX.
 - 4: white, all channels at MAX.
 - 5: eight vertical bars, bar = col*8/ACTIVE_COLS; bars 0-7 are white, yellow, cyan, green, magenta, red, blue, black (each channel MAX or 0).
 - 6: checkerboard; white when col[CB_SHIFT] XOR row[CB_SHIFT] = 1, else black.
 - 7: horizontal gradient; all channels = (col*2^VIDEO_WIDTH)/ACTIVE_COLS, truncated to VIDEO_WIDTH bits.
 - 8: border; white when col=0, col=ACTIVE_COLS-1, row=0 or row=ACTIVE_ROWS-1, else black.
 - 9-15: black.
REQ-018 Arithmetic for bar index and gradient is computed at full precision before truncation. col and row widths are clog2 of ACTIVE_COLS and ACTIVE_ROWS.
REQ-019 When a rising i_VSync edge and an active pixel occur in the same cycle, that pixel already uses the newly loaded mode.

Reset
REQ-020 While i_Reset=1 on a clock edge: all outputs, hs_d1, vs_d1, col and row clear to 0, and mode clears to 0 (black).
REQ-021 Reset asserted mid-frame forces black with syncs 0 from the next edge. After release, mode stays 0 until the next i_VSync rising edge.

Structure
REQ-022 A shared package holds the 4-bit pattern code constants (PAT_BLACK to PAT_BORDER) and the 8-entry colour-bar RGB table.
REQ-023 One sub-module, pixel_position_counter, implements REQ-014 and REQ-015 and outputs col, row and the frame-start pulse.

Verification
REQ-024 Reset mid-line with pattern 4 active -> next cycle all outputs 0. After release and before a new VSync rising edge, active pixels stay black.
REQ-025 Pattern 1, single active pixel pulse at cycle n -> o_Red=7, o_Green=0, o_Blue=0 at n+2 only. o_HSync and o_VSync are high exactly at n+2.
REQ-026 Pattern 5, 640 active cycles -> colour changes every 80 pixels in the order white, yellow, cyan, green, magenta, red, blue, black. Line position 639 is black.
REQ-027 Pattern 6, CB_SHIFT=5 -> row 0 col 31 black, col 32 white. Row 32 col 0 white.
REQ-028 i_Pattern changes 2 to 3 mid-frame -> rest of frame stays green. The next frame is blue from its first pixel.
REQ-029 Pattern 8, active line longer than 640 cycles -> col saturates at 639, so all pixels beyond 639 are white. Row 479 is all white; row 240 is white only at col 0 and col 639.
